// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register-slave endpoint.
// Address, data, response and valid/ready for all five channels.
interface axi4lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;

    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave that turns each bus access into one req/ack transfer
// on a simple register port, with alignment check and ack timeout.
module axi4lite_reg_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    axi4lite_reg_slave_if.slave     bus,
    output logic                    reg_req,
    output logic                    reg_wr,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int CW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t state;
    state_t nxt;

    logic                  live;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  last_was_read;
    logic [CW-1:0]         cnt;
    logic [1:0]            resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_rdy;
    logic                  w_rdy;
    logic                  ar_rdy;
    logic                  go_wr;
    logic                  go_rd;
    logic                  timed_out;
    logic                  write_pending;
    logic                  in_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [SW-1:0]         wr_strb;
    logic                  wr_mis;
    logic                  rd_mis;

    // A write half counts as present if held or handshaking now
    assign write_pending = (aw_held || bus.AWVALID) && (w_held || bus.WVALID);
    assign wr_addr = aw_held ? awaddr_q : bus.AWADDR;
    assign wr_data = w_held ? wdata_q : bus.WDATA;
    assign wr_strb = w_held ? wstrb_q : bus.WSTRB;
    assign wr_mis  = |wr_addr[LSB-1:0];
    assign rd_mis  = |bus.ARADDR[LSB-1:0];
    assign in_req  = (state == WR_REQ) || (state == RD_REQ);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        ar_rdy    = 1'b0;
        go_wr     = 1'b0;
        go_rd     = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (live) begin
                    aw_rdy = !aw_held;
                    w_rdy  = !w_held;
                    ar_rdy = !aw_held && !w_held &&
                             !(write_pending && last_was_read);
                    go_rd  = ar_rdy && bus.ARVALID;
                    go_wr  = write_pending && !go_rd;
                    if (go_rd) begin
                        nxt = rd_mis ? RD_RESP : RD_REQ;
                    end else if (go_wr) begin
                        nxt = wr_mis ? WR_RESP : WR_REQ;
                    end
                end
            end
            WR_REQ, RD_REQ: begin
                timed_out = !reg_ack && (cnt == LAST);
                if (reg_ack || timed_out) begin
                    nxt = (state == WR_REQ) ? WR_RESP : RD_RESP;
                end
            end
            WR_RESP: begin
                if (bus.BREADY) begin
                    nxt = IDLE;
                end
            end
            RD_RESP: begin
                if (bus.RREADY) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live          <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            last_was_read <= 1'b1;
            cnt           <= '0;
            resp_q        <= OKAY;
            rdata_q       <= '0;
            reg_wr        <= 1'b0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            reg_wstrb     <= '0;
        end else begin
            live <= 1'b1;
            cnt  <= (in_req && nxt == state) ? cnt + 1'b1 : '0;
            if (state == IDLE) begin
                if (go_wr) begin
                    aw_held   <= 1'b0;
                    w_held    <= 1'b0;
                    reg_wr    <= 1'b1;
                    reg_addr  <= wr_addr;
                    reg_wdata <= wr_data;
                    reg_wstrb <= wr_strb;
                    if (wr_mis) begin
                        resp_q  <= SLVERR;
                        rdata_q <= '0;
                    end
                end else begin
                    // Write halves arriving alongside a winning read wait here
                    if (aw_rdy && bus.AWVALID) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= bus.AWADDR;
                    end
                    if (w_rdy && bus.WVALID) begin
                        w_held  <= 1'b1;
                        wdata_q <= bus.WDATA;
                        wstrb_q <= bus.WSTRB;
                    end
                end
                if (go_rd) begin
                    reg_wr    <= 1'b0;
                    reg_addr  <= bus.ARADDR;
                    reg_wstrb <= '1;
                    if (rd_mis) begin
                        resp_q  <= SLVERR;
                        rdata_q <= '0;
                    end
                end
            end
            if (in_req) begin
                if (reg_ack) begin
                    resp_q <= reg_err ? SLVERR : OKAY;
                    if (state == RD_REQ) begin
                        rdata_q <= reg_rdata;
                    end
                end else if (timed_out) begin
                    resp_q  <= SLVERR;
                    rdata_q <= '0;
                end
            end
            if (state == WR_RESP && bus.BREADY) begin
                last_was_read <= 1'b0;
            end
            if (state == RD_RESP && bus.RREADY) begin
                last_was_read <= 1'b1;
            end
        end
    end

    assign bus.AWREADY = aw_rdy;
    assign bus.WREADY  = w_rdy;
    assign bus.ARREADY = ar_rdy;
    assign bus.BVALID  = (state == WR_RESP);
    assign bus.BRESP   = resp_q;
    assign bus.RVALID  = (state == RD_RESP);
    assign bus.RRESP   = resp_q;
    assign bus.RDATA   = rdata_q;
    assign reg_req     = in_req;

endmodule
